// File: rtl/fp_sqrt_rnd.sv
// fp_sqrt_rnd
// Iterative IEEE-754 square root with selectable rounding (truncate or
// round-to-nearest-even). Subnormal operands are normalised before the
// iteration. The restoring loop yields one root bit per cycle.
//
// Ports
//   clk, reset    : clock and synchronous active-high reset
//   in_valid      : operand handshake in; in_ready is high only in IDLE
//   in_ready      : operand handshake out
//   in_data       : operand, captured on the accept edge
//   rnd_mode      : 0 = truncate, 1 = RNE, captured on the accept edge
//   out_valid     : result handshake out
//   out_ready     : result handshake in
//   out_data      : result word, held stable until the result is taken
//   is_nan        : result flag, the result is NaN
//   is_pinf       : result flag, the result is +Inf
//   is_ninf       : result flag, never set because a root cannot be -Inf
//   is_invalid    : result flag, invalid operation
//   is_inexact    : result flag, the exact root was not representable
module fp_sqrt_rnd #(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         is_nan,
    output logic         is_pinf,
    output logic         is_ninf,
    output logic         is_invalid,
    output logic         is_inexact
);

    localparam int SW = $clog2(MAN_W + 1);
    localparam int CW = $clog2(MAN_W + 3);
    localparam int RW = MAN_W + 5;
    localparam int XW = 2 * MAN_W + 4;
    localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

    state_t             state;
    logic [W-1:0]       op;
    logic               mode;
    logic [CW-1:0]      cnt;
    logic [XW-1:0]      rad_sh;
    logic [RW-1:0]      rem;
    logic [MAN_W+1:0]   root;
    logic [EXP_W-1:0]   res_exp;

    assign in_ready = (state == IDLE) && !reset;
    assign is_ninf  = 1'b0;

    // Operand fields and classification of the latched operand.
    logic               op_sign;
    logic [EXP_W-1:0]   op_exp;
    logic [MAN_W-1:0]   op_frac;
    logic               exp_zero;
    logic               exp_ones;
    logic               frac_zero;

    assign {op_sign, op_exp, op_frac} = op;
    assign exp_zero  = (op_exp == '0);
    assign exp_ones  = &op_exp;
    assign frac_zero = (op_frac == '0);

    // Priority encoder: distance from the leading fraction 1 to the hidden
    // bit position. The highest set bit is visited last and wins.
    logic [SW-1:0] sub_shift;
    always_comb begin
        sub_shift = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (op_frac[i]) begin
                sub_shift = SW'(MAN_W - i);
            end
        end
    end

    // Normalised significand in [1,2), then the parity fix that makes the
    // unbiased exponent even so it halves exactly. exp_sum is
    // e + 2*bias, always even, so bits [EXP_W:1] are the result exponent.
    logic [MAN_W:0]   norm_sig;
    logic             exp_odd;
    logic [MAN_W+1:0] rad;
    logic [EXP_W+1:0] exp_base;
    logic [EXP_W+1:0] exp_sum;

    always_comb begin
        if (exp_zero) begin
            norm_sig = {1'b0, op_frac} << sub_shift;
            exp_odd  = sub_shift[0];
            exp_base = (EXP_W+2)'(1) - (EXP_W+2)'(sub_shift);
        end else begin
            norm_sig = {1'b1, op_frac};
            exp_odd  = ~op_exp[0];
            exp_base = {2'b00, op_exp};
        end
        rad     = exp_odd ? {norm_sig, 1'b0} : {1'b0, norm_sig};
        exp_sum = exp_base + BIAS - {{(EXP_W+1){1'b0}}, exp_odd};
    end

    // Special operands bypass the iteration and load the result directly.
    logic         special;
    logic [W-1:0] spec_data;
    logic         spec_nan;
    logic         spec_pinf;
    logic         spec_invalid;

    always_comb begin
        special      = 1'b1;
        spec_data    = QNAN;
        spec_nan     = 1'b0;
        spec_pinf    = 1'b0;
        spec_invalid = 1'b0;
        if (exp_ones && !frac_zero) begin
            spec_nan     = 1'b1;
            spec_invalid = ~op_frac[MAN_W-1];
        end else if (exp_ones && !op_sign) begin
            spec_data = PINF;
            spec_pinf = 1'b1;
        end else if (exp_zero && frac_zero) begin
            spec_data = op;
        end else if (op_sign) begin
            spec_nan     = 1'b1;
            spec_invalid = 1'b1;
        end else begin
            special = 1'b0;
        end
    end

    // One restoring root step: bring down two radicand bits and try
    // subtracting 4q+1.
    logic [RW-1:0]    rem_sh;
    logic [RW-1:0]    trial;
    logic             take;
    logic [RW-1:0]    rem_nx;
    logic [MAN_W+1:0] root_nx;

    assign rem_sh  = {rem[RW-3:0], rad_sh[XW-1:XW-2]};
    assign trial   = {1'b0, root, 2'b01};
    assign take    = (rem_sh >= trial);
    assign rem_nx  = take ? (rem_sh - trial) : rem_sh;
    assign root_nx = {root[MAN_W:0], take};

    // Rounding: root[0] is the guard bit and a non-zero remainder is sticky.
    logic             guard;
    logic             sticky;
    logic             inc;
    logic [MAN_W+1:0] rnd_sum;
    logic [EXP_W-1:0] rnd_exp;

    assign guard   = root[0];
    assign sticky  = |rem;
    assign inc     = mode & guard & (sticky | root[1]);
    assign rnd_sum = {1'b0, root[MAN_W+1:1]} + (MAN_W+2)'(inc);
    assign rnd_exp = res_exp + EXP_W'(rnd_sum[MAN_W+1]);

    // exp_sum is always even and never reaches its top bit; the hidden bit
    // of the rounded sum is implied in the packed result.
    logic unused_bits;
    assign unused_bits = ^{exp_sum[EXP_W+1], exp_sum[0], rnd_sum[MAN_W]};

    // Control and datapath registers. The counter counts root bits still
    // to be produced; the last one moves the unit to ROUND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            is_nan     <= 1'b0;
            is_pinf    <= 1'b0;
            is_invalid <= 1'b0;
            is_inexact <= 1'b0;
            op         <= '0;
            mode       <= 1'b0;
            cnt        <= '0;
            rad_sh     <= '0;
            rem        <= '0;
            root       <= '0;
            res_exp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= in_data;
                        mode  <= rnd_mode;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        out_data   <= spec_data;
                        is_nan     <= spec_nan;
                        is_pinf    <= spec_pinf;
                        is_invalid <= spec_invalid;
                        is_inexact <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        rad_sh  <= {rad, {(MAN_W+2){1'b0}}};
                        rem     <= '0;
                        root    <= '0;
                        res_exp <= exp_sum[EXP_W:1];
                        cnt     <= CW'(MAN_W + 2);
                        state   <= ITER;
                    end
                end
                ITER: begin
                    rad_sh <= rad_sh << 2;
                    rem    <= rem_nx;
                    root   <= root_nx;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_data   <= {1'b0, rnd_exp, rnd_sum[MAN_W-1:0]};
                    is_nan     <= 1'b0;
                    is_pinf    <= 1'b0;
                    is_invalid <= 1'b0;
                    is_inexact <= guard | sticky;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_rnd.sv
// tb_fp_sqrt_rnd
// Drives an fp16 and an fp32 instance of fp_sqrt_rnd with directed
// operands. Expected results are queued when an operand is accepted; a
// monitor per instance pops and compares when out_valid rises, checks the
// latency, and checks that the output stays stable while it is held.
`timescale 1ns/1ps
module tb_fp_sqrt_rnd;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid, in_ready, rnd_mode, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic        is_nan, is_pinf, is_ninf, is_invalid, is_inexact;

    logic        in_valid_32, in_ready_32, rnd_mode_32, out_valid_32, out_ready_32;
    logic [31:0] in_data_32, out_data_32;
    logic        is_nan_32, is_pinf_32, is_ninf_32, is_invalid_32, is_inexact_32;

    exp_t q16[$];
    exp_t q32[$];
    exp_t cur16, cur32;
    bit   have16 = 0, have32 = 0;
    bit   prev16 = 0, prev32 = 0;

    fp_sqrt_rnd #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .is_nan(is_nan), .is_pinf(is_pinf), .is_ninf(is_ninf),
        .is_invalid(is_invalid), .is_inexact(is_inexact)
    );

    fp_sqrt_rnd #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_32), .in_ready(in_ready_32), .in_data(in_data_32), .rnd_mode(rnd_mode_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32), .out_data(out_data_32),
        .is_nan(is_nan_32), .is_pinf(is_pinf_32), .is_ninf(is_ninf_32),
        .is_invalid(is_invalid_32), .is_inexact(is_inexact_32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL timeout_%s: bound expired waiting for the DUT", name);
    endtask

    // Waits for in_ready, presents one operand and queues its expected result.
    task automatic applyStimulus(input bit wide, input logic [31:0] data, input logic mode,
                                 input logic [31:0] exp_data, input logic [4:0] exp_flags,
                                 input int exp_lat);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (!(wide ? in_ready_32 : in_ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            timeoutFail("accept");
            return;
        end
        if (wide) begin
            in_valid_32 = 1'b1; in_data_32 = data; rnd_mode_32 = mode;
        end else begin
            in_valid = 1'b1; in_data = data[15:0]; rnd_mode = mode;
        end
        @(posedge clk);
        #1;
        e.data = exp_data; e.flags = exp_flags; e.lat = exp_lat; e.acc = cyc;
        if (wide) begin
            q32.push_back(e);
            in_valid_32 = 1'b0;
        end else begin
            q16.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    // Waits until every queued result has been seen by the monitor.
    task automatic waitDrain(input bit wide);
        int waited = 0;
        while ((wide ? q32.size() : q16.size()) != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            timeoutFail(wide ? "drain32" : "drain16");
            if (wide) q32.delete(); else q16.delete();
        end
        @(negedge clk);
    endtask

    // fp16 monitor: compare on the rising edge of out_valid, then check the
    // held result for stability on every further cycle it stays valid.
    always @(negedge clk) begin
        if (out_valid) begin
            if (!prev16) begin
                if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    have16 = 0;
                    $display("[TB] FAIL unexpected_out16: got data %0h with nothing queued", out_data);
                end else begin
                    cur16 = q16.pop_front();
                    have16 = 1;
                    checkOutput("data16", 64'(out_data), 64'(cur16.data));
                    checkOutput("flags16", 64'({is_nan, is_pinf, is_ninf, is_invalid, is_inexact}),
                                64'(cur16.flags));
                    checkOutput("latency16", 64'(cyc - cur16.acc), 64'(cur16.lat));
                end
            end else if (have16) begin
                checkOutput("hold_data16", 64'(out_data), 64'(cur16.data));
                checkOutput("hold_flags16", 64'({is_nan, is_pinf, is_ninf, is_invalid, is_inexact}),
                            64'(cur16.flags));
            end
        end
        prev16 = out_valid;
    end

    // fp32 monitor, same scheme.
    always @(negedge clk) begin
        if (out_valid_32) begin
            if (!prev32) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    have32 = 0;
                    $display("[TB] FAIL unexpected_out32: got data %0h with nothing queued", out_data_32);
                end else begin
                    cur32 = q32.pop_front();
                    have32 = 1;
                    checkOutput("data32", 64'(out_data_32), 64'(cur32.data));
                    checkOutput("flags32", 64'({is_nan_32, is_pinf_32, is_ninf_32, is_invalid_32,
                                                is_inexact_32}), 64'(cur32.flags));
                    checkOutput("latency32", 64'(cyc - cur32.acc), 64'(cur32.lat));
                end
            end else if (have32) begin
                checkOutput("hold_data32", 64'(out_data_32), 64'(cur32.data));
            end
        end
        prev32 = out_valid_32;
    end

    // Watchdog against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Flag order everywhere: {nan, pinf, ninf, invalid, inexact}.
    initial begin
        int waited;
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; rnd_mode = 1'b0; out_ready = 1'b1;
        in_valid_32 = 1'b0; in_data_32 = '0; rnd_mode_32 = 1'b0; out_ready_32 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("in_ready_in_reset", 64'(in_ready), 64'(0));
        checkOutput("out_valid_in_reset", 64'(out_valid), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1));
        checkOutput("out_data_after_reset", 64'(out_data), 64'(0));
        checkOutput("flags_after_reset", 64'({is_nan, is_pinf, is_ninf, is_invalid, is_inexact}), 64'(0));

        // fp16 specials, all at one-edge latency
        applyStimulus(0, 32'h7C00, 0, 32'h7C00, 5'b01000, 1);  waitDrain(0);
        applyStimulus(0, 32'hFC00, 0, 32'hFE00, 5'b10010, 1);  waitDrain(0);
        applyStimulus(0, 32'hBC00, 1, 32'hFE00, 5'b10010, 1);  waitDrain(0);
        applyStimulus(0, 32'h7D00, 0, 32'hFE00, 5'b10010, 1);  waitDrain(0);
        applyStimulus(0, 32'h7E00, 0, 32'hFE00, 5'b10000, 1);  waitDrain(0);
        applyStimulus(0, 32'h8000, 0, 32'h8000, 5'b00000, 1);  waitDrain(0);
        applyStimulus(0, 32'h0000, 1, 32'h0000, 5'b00000, 1);  waitDrain(0);

        // fp16 rounding modes and subnormals
        applyStimulus(0, 32'h4200, 0, 32'h3EED, 5'b00001, 14); waitDrain(0);
        applyStimulus(0, 32'h4200, 1, 32'h3EEE, 5'b00001, 14); waitDrain(0);
        applyStimulus(0, 32'h4400, 1, 32'h4000, 5'b00000, 14); waitDrain(0);
        applyStimulus(0, 32'h7BFF, 0, 32'h5BFF, 5'b00001, 14); waitDrain(0);
        applyStimulus(0, 32'h7BFF, 1, 32'h5BFF, 5'b00001, 14); waitDrain(0);
        applyStimulus(0, 32'h0001, 1, 32'h0C00, 5'b00000, 14); waitDrain(0);
        applyStimulus(0, 32'h03FF, 0, 32'h1FFE, 5'b00001, 14); waitDrain(0);
        applyStimulus(0, 32'h03FF, 1, 32'h1FFF, 5'b00001, 14); waitDrain(0);

        // Back-pressure, with a second operand presented while in DONE
        out_ready = 1'b0;
        applyStimulus(0, 32'h4400, 0, 32'h4000, 5'b00000, 14);
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) timeoutFail("bp_valid");
        in_valid = 1'b1; in_data = 16'h4880; rnd_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("in_ready_held", 64'(in_ready), 64'(0));
            checkOutput("out_valid_held", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_release", 64'(in_ready), 64'(1));
        checkOutput("out_valid_after_release", 64'(out_valid), 64'(0));
        repeat (20) @(negedge clk);

        // Reset during ITER discards the operation
        applyStimulus(0, 32'h4200, 0, 32'h3EED, 5'b00001, 14);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q16.delete();
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(out_data), 64'(0));
        checkOutput("rst_flags", 64'({is_nan, is_pinf, is_ninf, is_invalid, is_inexact}), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("no_valid_after_rst", 64'(out_valid), 64'(0));
        applyStimulus(0, 32'h4880, 0, 32'h4200, 5'b00000, 14); waitDrain(0);

        // fp32 instance
        applyStimulus(1, 32'h40800000, 0, 32'h40000000, 5'b00000, 27); waitDrain(1);
        applyStimulus(1, 32'h40000000, 0, 32'h3FB504F3, 5'b00001, 27); waitDrain(1);
        applyStimulus(1, 32'h40000000, 1, 32'h3FB504F3, 5'b00001, 27); waitDrain(1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_rnd.md
# fp_sqrt_rnd

Parametrised IEEE-754 binary square-root unit: the successor to the fixed fp16 `sqrt2` core. Format width is set by `EXP_W`/`MAN_W`, and rounding is selectable per operation (truncate or round-to-nearest-even). Subnormal inputs are fully normalised. The bidirectional data bus is replaced by valid/ready handshakes on separate input and output ports. The unit sits in the FP datapath as a multi-cycle, non-pipelined iterative unit that computes one root bit per cycle.

## Interface
- `EXP_W`, default 5: exponent width; legal range 5..11.
- `MAN_W`, default 10: stored fraction width; legal range 7..52. Word width W = 1+EXP_W+MAN_W.
- `CLK` input, 1 bit: clock; all state is updated on the rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `IN_VALID` input, 1 bit: an operand is presented.
- `IN_READY` output, 1 bit: the unit can accept an operand.
- `IN_DATA` input, W bits: IEEE operand.
- `RND_MODE` input, 1 bit: 0 selects truncate (toward zero), 1 selects RNE. Sampled together with `IN_DATA`.
- `OUT_VALID` output, 1 bit: the result and flags are valid.
- `OUT_READY` input, 1 bit: the consumer accepts the result.
- `OUT_DATA` output, W bits: IEEE result.
- `IS_NAN` output, 1 bit: the result is NaN.
- `IS_PINF` output, 1 bit: the result is +Inf.
- `IS_NINF` output, 1 bit: always 0; the port is kept for flag-bus compatibility.
- `IS_INVALID` output, 1 bit: invalid operation (negative non-zero operand, -Inf, or sNaN).
- `IS_INEXACT` output, 1 bit: the exact root was not representable.

## Operation
- **States:** IDLE, UNPACK, ITER, ROUND, DONE.
- **IDLE:**
  - `IN_READY`=1.
  - On `IN_VALID`&`IN_READY`, latch `IN_DATA` and `RND_MODE`, then go to UNPACK.
- **UNPACK (1 cycle):** classify the operand; specials load the result directly and go to DONE.
  - Any NaN gives canonical qNaN: sign 1, exponent all-ones, fraction MSB 1, rest 0 (fp16 0xFE00). `IS_NAN`=1. `IS_INVALID`=1 for sNaN only.
  - -Inf, or a negative finite non-zero operand, gives qNaN with `IS_NAN`=1 and `IS_INVALID`=1.
  - +Inf gives +Inf with `IS_PINF`=1.
  - ±0 is passed through with its sign preserved.
- **Normalisation (finite positive operands):**
  - Subnormals are normalised in one cycle with a priority encoder: shift the leading 1 to the hidden position and adjust the unbiased exponent e.
  - If e is odd, shift the significand left by 1 and decrement e.
  - Result exponent = e/2 + bias. The result is always normal; no overflow or underflow is possible.
  - Load counter = MAN_W+2 and go to ITER.
- **ITER:**
  - Restoring digit-by-digit root, one result bit per cycle.
  - Radicand in [1,4), root in [1,2).
  - Produces MAN_W+1 root bits plus 1 guard bit; sticky = remainder≠0.
  - Go to ROUND when the counter reaches 0.
- **ROUND (1 cycle):**
  - Truncate: drop the guard bit.
  - RNE: increment when guard=1 and (sticky=1 or LSB=1). A carry out of the significand increments the exponent.
  - `IS_INEXACT` = guard | sticky.
  - Go to DONE.
- **DONE:**
  - `OUT_VALID`=1. `OUT_DATA` and all flags are registered and held stable while `OUT_READY`=0.
  - On `OUT_READY`, go to IDLE.
- `IN_READY` = (state==IDLE) & !`RESET`. `IN_DATA` and `RND_MODE` are ignored outside the accept edge.
- **Reset:**
  - Forces state IDLE, `OUT_VALID`=0, `OUT_DATA`=0, all flags 0.
  - An operation in flight is discarded and produces no `OUT_VALID`.

## Timing
- Let k be the accept edge. UNPACK is active in the cycle after k.
- Special operands: `OUT_VALID` rises after edge k+1.
- Finite positive operands: `OUT_VALID` rises after edge k+MAN_W+4. This is 14 edges for fp16 and 27 for fp32, independent of subnormality.
- The output handshake completes on the edge with `OUT_VALID`&`OUT_READY`. `IN_READY` is 1 from the following cycle.
- Minimum issue interval for a finite operand is MAN_W+6 cycles when `OUT_READY` is held high.
- If `RESET` is asserted in any state, all outputs show reset values after that edge. `IN_READY` is 0 while `RESET`=1.

## Test plan
- **fp16 specials:**
  - 0x7C00 gives 0x7C00 with `IS_PINF` set.
  - 0xFC00, 0xBC00 and 0x7D00 each give 0xFE00 with `IS_NAN` and `IS_INVALID` set.
  - 0x7E00 gives 0xFE00 with `IS_NAN` set and `IS_INVALID` clear.
  - 0x8000 gives 0x8000; 0x0000 gives 0x0000.
  - All specials arrive at latency 1 edge.
- **fp16 rounding modes:**
  - 0x4200 (3.0) gives 0x3EED in truncate and 0x3EEE in RNE, with `IS_INEXACT` set.
  - 0x4400 gives 0x4000 with `IS_INEXACT` clear.
  - 0x7BFF gives 0x5BFF in both modes with `IS_INEXACT` set.
- **fp16 subnormals:**
  - 0x0001 gives 0x0C00, exact.
  - 0x03FF gives 0x1FFE in truncate and 0x1FFF in RNE, inexact.
  - Latency is 14 edges, the same as for normal operands.
- **fp32 build (EXP_W=8, MAN_W=23):**
  - 0x40800000 gives 0x40000000.
  - 0x40000000 gives 0x3FB504F3 in both modes, inexact.
  - Latency is 27 edges.
- **Back-pressure:**
  - Hold `OUT_READY`=0 for 5 cycles after `OUT_VALID`. `OUT_DATA` and flags stay constant and `IN_READY` stays 0.
  - Release `OUT_READY`; `IN_READY`=1 on the next cycle.
  - Apply a second operand with the opposite `RND_MODE` while the first is in DONE; it must not be accepted.
- **Reset mid-operation:**
  - Assert `RESET` for 1 cycle during ITER of 0x4200.
  - No `OUT_VALID` appears, and all outputs are 0.
  - A subsequent 0x4880 gives 0x4200 at normal latency.
